// File: rtl/scmp_status_reg.sv
// SC/MP status register: ALU flag write-back, CAS load, interrupt enable,
// sense-pin synchronisers and the interrupt request.
module scmp_status_reg #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       upd_cy_i,
    input  logic       upd_ov_i,
    input  logic       alu_cy_i,
    input  logic       alu_hcy_i,
    input  logic       alu_ov_i,
    input  logic       sr_wr_i,
    input  logic [7:0] sr_d_i,
    input  logic       ien_i,
    input  logic       dint_i,
    input  logic       irq_ack_i,
    input  logic       sense_a_i,
    input  logic       sense_b_i,
    output logic [7:0] sr_o,
    output logic       cy_o,
    output logic       ov_o,
    output logic       hcy_o,
    output logic [2:0] flags_o,
    output logic       irq_o
);

    logic                   cy_q, cy_d;
    logic                   ov_q, ov_d;
    logic                   hcy_q, hcy_d;
    logic                   ie_q, ie_d;
    logic [2:0]             f_q, f_d;
    logic [SYNC_STAGES-1:0] sa_sync_q, sb_sync_q;
    logic                   sa, sb;

    // ALU strobes override the CAS value bit by bit; IE follows its own priority.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        cy_d  = cy_q;
        ov_d  = ov_q;
        hcy_d = hcy_q;
        f_d   = f_q;
        ie_d  = ie_q;

        if (sr_wr_i) begin
            cy_d  = sr_d_i[7];
            ov_d  = sr_d_i[6];
            hcy_d = 1'b0;
            f_d   = sr_d_i[2:0];
        end
        if (upd_cy_i) begin
            cy_d  = alu_cy_i;
            hcy_d = alu_hcy_i;
        end
        if (upd_ov_i) begin
            ov_d = alu_ov_i;
        end

        if (irq_ack_i || dint_i) begin
            ie_d = 1'b0;
        end else if (ien_i) begin
            ie_d = 1'b1;
        end else if (sr_wr_i) begin
            ie_d = sr_d_i[3];
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            cy_q      <= 1'b0;
            ov_q      <= 1'b0;
            hcy_q     <= 1'b0;
            ie_q      <= 1'b0;
            f_q       <= '0;
            // NOTE: synchroniser flops are reset too, so stale pin history cannot raise irq after reset.
            sa_sync_q <= '0;
            sb_sync_q <= '0;
        end else begin
            cy_q      <= cy_d;
            ov_q      <= ov_d;
            hcy_q     <= hcy_d;
            ie_q      <= ie_d;
            f_q       <= f_d;
            sa_sync_q <= {sa_sync_q[SYNC_STAGES-2:0], sense_a_i};
            sb_sync_q <= {sb_sync_q[SYNC_STAGES-2:0], sense_b_i};
        end
    end

    assign sa      = sa_sync_q[SYNC_STAGES-1];
    assign sb      = sb_sync_q[SYNC_STAGES-1];

    assign sr_o    = {cy_q, ov_q, sb, sa, ie_q, f_q};
    assign cy_o    = cy_q;
    assign ov_o    = ov_q;
    assign hcy_o   = hcy_q;
    assign flags_o = f_q;
    assign irq_o   = ie_q & sa;

endmodule

// File: tb/tb_scmp_status_reg.sv
// Directed self-checking bench for scmp_status_reg with hand-computed expectations.
module tb_scmp_status_reg;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       upd_cy_i, upd_ov_i;
    logic       alu_cy_i, alu_hcy_i, alu_ov_i;
    logic       sr_wr_i;
    logic [7:0] sr_d_i;
    logic       ien_i, dint_i, irq_ack_i;
    logic       sense_a_i, sense_b_i;
    logic [7:0] sr_o;
    logic       cy_o, ov_o, hcy_o, irq_o;
    logic [2:0] flags_o;

    int checks   = 0;
    int failures = 0;

    scmp_status_reg #(.SYNC_STAGES(2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .upd_cy_i  (upd_cy_i),
        .upd_ov_i  (upd_ov_i),
        .alu_cy_i  (alu_cy_i),
        .alu_hcy_i (alu_hcy_i),
        .alu_ov_i  (alu_ov_i),
        .sr_wr_i   (sr_wr_i),
        .sr_d_i    (sr_d_i),
        .ien_i     (ien_i),
        .dint_i    (dint_i),
        .irq_ack_i (irq_ack_i),
        .sense_a_i (sense_a_i),
        .sense_b_i (sense_b_i),
        .sr_o      (sr_o),
        .cy_o      (cy_o),
        .ov_o      (ov_o),
        .hcy_o     (hcy_o),
        .flags_o   (flags_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_strobes();
        upd_cy_i  = 1'b0;
        upd_ov_i  = 1'b0;
        sr_wr_i   = 1'b0;
        ien_i     = 1'b0;
        dint_i    = 1'b0;
        irq_ack_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle_strobes();
        alu_cy_i  = 1'b0;
        alu_hcy_i = 1'b0;
        alu_ov_i  = 1'b0;
        sr_d_i    = 8'h00;
        sense_a_i = 1'b0;
        sense_b_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;

        check("rst_sr",    sr_o,            8'h00);
        check("rst_irq",   {7'b0, irq_o},   8'h00);
        check("rst_flags", {5'b0, flags_o}, 8'h00);
        check("rst_cyovh", {5'b0, cy_o, ov_o, hcy_o}, 8'h00);

        // CAS FF with SA=SB=0: bits 5:4 stay at the synchronised pins.
        sr_wr_i = 1'b1; sr_d_i = 8'hFF;
        step();
        idle_strobes();
        check("cas_ff_sr",    sr_o,            8'hCF);
        check("cas_ff_flags", {5'b0, flags_o}, 8'h07);
        check("cas_ff_hcy",   {7'b0, hcy_o},   8'h00);

        sr_wr_i = 1'b1; sr_d_i = 8'h00;
        step();
        idle_strobes();
        check("cas_00_sr", sr_o, 8'h00);

        // upd_cy alone: OV must not follow alu_ov.
        upd_cy_i = 1'b1; alu_cy_i = 1'b1; alu_hcy_i = 1'b1; alu_ov_i = 1'b1;
        step();
        idle_strobes();
        check("updcy_cyovh", {5'b0, cy_o, ov_o, hcy_o}, 8'h05);
        check("updcy_sr",    sr_o, 8'h80);

        upd_ov_i = 1'b1; alu_ov_i = 1'b1;
        step();
        idle_strobes();
        check("updov_cyovh", {5'b0, cy_o, ov_o, hcy_o}, 8'h07);

        // CAS 00 with upd_cy: CY from ALU, OV from CAS, HCY from ALU.
        sr_wr_i = 1'b1; sr_d_i = 8'h00; upd_cy_i = 1'b1; alu_cy_i = 1'b1; alu_hcy_i = 1'b0;
        step();
        idle_strobes();
        check("cas_updcy_cyovh", {5'b0, cy_o, ov_o, hcy_o}, 8'h04);

        // CAS FF with upd_cy carrying cy=0, hcy=1.
        sr_wr_i = 1'b1; sr_d_i = 8'hFF; upd_cy_i = 1'b1; alu_cy_i = 1'b0; alu_hcy_i = 1'b1;
        step();
        idle_strobes();
        check("cas_ff_updcy_sr",  sr_o,          8'h4F);
        check("cas_ff_updcy_hcy", {7'b0, hcy_o}, 8'h01);

        sr_wr_i = 1'b1; sr_d_i = 8'h00;
        step();
        idle_strobes();
        check("clear_sr", sr_o, 8'h00);

        // SA rising: visible after the second edge.
        sense_a_i = 1'b1;
        step();
        check("sa_sync1", sr_o, 8'h00);
        step();
        check("sa_sync2", sr_o, 8'h10);
        check("sa_noie_irq", {7'b0, irq_o}, 8'h00);

        ien_i = 1'b1;
        step();
        idle_strobes();
        check("ien_irq", {7'b0, irq_o}, 8'h01);
        check("ien_sr",  sr_o,          8'h18);

        irq_ack_i = 1'b1; ien_i = 1'b1;
        step();
        idle_strobes();
        check("ack_ien_irq", {7'b0, irq_o}, 8'h00);
        check("ack_ien_sr",  sr_o,          8'h10);

        ien_i = 1'b1;
        step();
        idle_strobes();
        dint_i = 1'b1; ien_i = 1'b1;
        step();
        idle_strobes();
        check("dint_ien_irq", {7'b0, irq_o}, 8'h00);

        // IEN beats CAS d[3]=0.
        ien_i = 1'b1; sr_wr_i = 1'b1; sr_d_i = 8'h00;
        step();
        idle_strobes();
        check("ien_cas_sr", sr_o, 8'h18);

        // SB rising with a CAS d[5]=0 in flight.
        sense_b_i = 1'b1; sr_wr_i = 1'b1; sr_d_i = 8'h00;
        step();
        idle_strobes();
        check("sb_sync1", sr_o, 8'h10);
        sr_wr_i = 1'b1; sr_d_i = 8'hDF;
        step();
        idle_strobes();
        check("sb_sync2_cas", sr_o, 8'hFF);
        check("sb_irq",       {7'b0, irq_o}, 8'h01);

        // Reset overrides IEN and ALU strobes in the same cycle.
        rst_i = 1'b1; ien_i = 1'b1; upd_cy_i = 1'b1; alu_cy_i = 1'b1;
        step();
        rst_i = 1'b0;
        idle_strobes();
        check("midrst_sr",  sr_o,          8'h00);
        check("midrst_irq", {7'b0, irq_o}, 8'h00);
        step();
        check("post_rst1_sr", sr_o, 8'h00);
        step();
        check("post_rst2_sr",  sr_o,          8'h30);
        check("post_rst2_irq", {7'b0, irq_o}, 8'h00);
        ien_i = 1'b1;
        step();
        idle_strobes();
        check("fresh_ien_irq", {7'b0, irq_o}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scmp_status_reg.md
# scmp_status_reg

SC/MP status register and flag write-back unit: the consumer of the ALU's flag outputs and the source of the ALU's flag inputs. It registers carry/link, overflow and half-carry, and synchronises the external sense inputs SA and SB. It also holds the interrupt-enable bit and the three user flag outputs F0-F2, and raises the interrupt request. It sits between the microcode sequencer, the ALU and the CPU pins; CAS/CSA, IEN/DINT and interrupt acknowledge are driven by microcode strobes.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop stages on each sense input; legal values 2-3.

Ports:
- clk_i  in  1  CPU clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- upd_cy_i  in  1  latch `alu_cy_i` into CY/L and `alu_hcy_i` into HCY.
- upd_ov_i  in  1  latch `alu_ov_i` into OV.
- alu_cy_i  in  1  ALU carry out.
- alu_hcy_i  in  1  ALU half-carry out.
- alu_ov_i  in  1  ALU overflow out.
- sr_wr_i  in  1  CAS strobe: load SR from `sr_d_i`.
- sr_d_i  in  8  new SR value (accumulator).
- ien_i  in  1  IEN strobe: set IE.
- dint_i  in  1  DINT strobe: clear IE.
- irq_ack_i  in  1  interrupt taken: clear IE.
- sense_a_i  in  1  asynchronous SA pin.
- sense_b_i  in  1  asynchronous SB pin.
- sr_o  out  8  {CY, OV, SB, SA, IE, F2, F1, F0}; CSA read value.
- cy_o  out  1  CY/L to ALU `Cy_i`.
- ov_o  out  1  OV to ALU `Ov_i`.
- hcy_o  out  1  latched half-carry to ALU `HCy_i` (DAD).
- flags_o  out  3  F2..F0 pins.
- irq_o  out  1  interrupt request.

## Operation
- Registers:
  - CY, OV, HCY, IE and F[2:0] are stored bits.
  - SA and SB are the outputs of the final synchroniser stage.
  - sr_o[5:4] always reflect the synchronised pins and are never written.
- CAS (`sr_wr_i`):
  - CY ← d[7], OV ← d[6], IE ← d[3], F ← d[2:0].
  - HCY ← 0.
  - d[5:4] are ignored.
- ALU write-back:
  - `upd_cy_i` sets CY ← `alu_cy_i` and HCY ← `alu_hcy_i`.
  - `upd_ov_i` sets OV ← `alu_ov_i`.
  - The two strobes are independent.
- Same-cycle priority for CY/OV/HCY: ALU update beats `sr_wr_i`, bit by bit. A bit not selected for update takes the `sr_wr_i` value if `sr_wr_i` is high, otherwise holds.
- Same-cycle priority for IE: `irq_ack_i` > `dint_i` > `ien_i` > `sr_wr_i` (d[3]) > hold.
- Interrupt request: `irq_o` = IE & SA, a combinational AND of registered bits. It stays asserted until IE is cleared; the sequencer must assert `irq_ack_i`.
- Synchroniser: SYNC_STAGES flops per pin; no filtering.
- Reset: all state bits, including synchroniser flops, go to 0.
  - sr_o = 8'h00, cy_o = ov_o = hcy_o = 0, flags_o = 3'b000, irq_o = 0.
  - Reset overrides every strobe in the same cycle.

## Timing
- Strobes sampled at edge N; the new value is visible on the outputs after edge N. Write latency is one cycle.
- Pin to sr_o[5:4]: SYNC_STAGES edges. With the default of 2, a level change on `sense_a_i` before edge N appears after edge N+1.
- `irq_o` changes in the same cycle that IE or SA changes. There is no extra register stage.
- Reads (sr_o, cy_o, ov_o, hcy_o) are combinational from registers. The ALU sees a flag written at edge N from cycle N+1 onward, so back-to-back flag-dependent ops need no stall.
- Reset asserted mid-sequence (e.g. between IEN and the pending interrupt) clears IE and the synchronisers at the next edge. `irq_o` is 0 from then until IE is set again and SA has resynchronised.

## Test plan
- Reset → sr_o=8'h00, irq_o=0. Then CAS with d=8'hFF and SA=SB=0 → sr_o=8'hCF, flags_o=3'b111, hcy_o=0.
- `upd_cy_i` with alu_cy=1, alu_hcy=1, alu_ov=1 but `upd_ov_i`=0 → cy_o=1, hcy_o=1, ov_o unchanged (0).
- Same-cycle CAS d=8'h00 with `upd_cy_i`, alu_cy=1 → CY=1, OV=0, HCY=alu_hcy.
- Hold SA=1 and pulse IEN → irq_o=1 one cycle after IEN. Then `irq_ack_i` and `ien_i` in the same cycle → IE=0, irq_o=0.
- Toggle `sense_b_i` 0→1 just before edge N → sr_o[5]=0 after edge N, 1 after edge N+1. A CAS with d[5]=0 during this does not alter sr_o[5].
- IE=1, SA=1, irq_o=1, then assert rst_i for one cycle while `ien_i`=1 → sr_o=8'h00 and irq_o=0 after the edge, and irq_o stays 0 until a fresh IEN.
